// File: rtl/tcp_port_dispatch.sv
// TCP destination-port dispatcher: looks the packet's destination port up in a small
// configurable table and steers the AXIS payload to the matching socket lane, or drops it.
module tcp_port_dispatch #(
    parameter int NUM_SOCK = 4,
    parameter int IDX_W    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_we,
    input  logic [IDX_W-1:0]      i_cfg_idx,
    input  logic [15:0]           i_cfg_port,
    input  logic                  i_cfg_en,
    input  logic [15:0]           i_tcp_dest,
    input  logic                  i_tcp_dest_valid,
    input  logic [7:0]            s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [NUM_SOCK*8-1:0] m_tdata,
    output logic [NUM_SOCK-1:0]   m_tvalid,
    output logic [NUM_SOCK-1:0]   m_tlast,
    input  logic [NUM_SOCK-1:0]   m_tready,
    output logic [15:0]           o_drop_count,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        FORWARD = 3'd2,
        DROP    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          sel_q, sel_d;
    logic [NUM_SOCK-1:0][15:0] port_q, port_d;
    logic [NUM_SOCK-1:0]       en_q, en_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;
    logic                      hit_s;
    logic [IDX_W-1:0]          hit_idx_s;

    // Port-table update from the config strobe
    always_comb begin
        port_d = port_q;
        en_d   = en_q;
        if (i_cfg_we) begin
            port_d[i_cfg_idx] = i_cfg_port;
            en_d[i_cfg_idx]   = i_cfg_en;
        end else begin
            en_d = en_q;
        end
    end

    // Priority match against the registered table; scanning downward lets the lowest index win
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = NUM_SOCK - 1; i >= 0; i--) begin
            hit_idx_s = (en_q[i] && (port_q[i] == i_tcp_dest)) ? IDX_W'(i) : hit_idx_s;
            hit_s     = hit_s | (en_q[i] && (port_q[i] == i_tcp_dest));
        end
    end

    // Next-state, lane steering and drop counting
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        drop_cnt_d = drop_cnt_q;
        s_tready   = 1'b0;
        m_tvalid   = '0;
        m_tlast    = '0;
        m_tdata    = {NUM_SOCK{s_tdata}};
        o_busy     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = i_tcp_dest_valid ? LOOKUP : IDLE;
            end
            LOOKUP: begin
                sel_d   = hit_idx_s;
                state_d = hit_s ? FORWARD : DROP;
            end
            FORWARD: begin
                s_tready        = m_tready[sel_q];
                m_tvalid[sel_q] = s_tvalid;
                m_tlast[sel_q]  = s_tlast;
                if (s_tvalid && m_tready[sel_q] && s_tlast) begin
                    state_d = DONE;
                end else begin
                    state_d = FORWARD;
                end
            end
            DROP: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    state_d    = DONE;
                    drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? 16'hFFFF : drop_cnt_q + 16'd1;
                end else begin
                    state_d = DROP;
                end
            end
            DONE: begin
                // Waiting for valid to fall keeps a held valid from re-dispatching the packet
                state_d = i_tcp_dest_valid ? DONE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (i_rst) begin
            s_tready = 1'b0;
            m_tvalid = '0;
            m_tlast  = '0;
        end else begin
            o_busy = (state_q != IDLE);
        end
    end

    // State, selection, table and counter registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            port_q     <= '0;
            en_q       <= '0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            port_q     <= port_d;
            en_q       <= en_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_tcp_port_dispatch.sv
// Self-checking bench for tcp_port_dispatch: directed vector table, hand sequences for
// reset/saturation corners, and random packets against a packet-level reference model.
module tb_tcp_port_dispatch;

    localparam int NS = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            i_rst;
    logic            i_cfg_we;
    logic [IW-1:0]   i_cfg_idx;
    logic [15:0]     i_cfg_port;
    logic            i_cfg_en;
    logic [15:0]     i_tcp_dest;
    logic            i_tcp_dest_valid;
    logic [7:0]      s_tdata;
    logic            s_tvalid;
    logic            s_tlast;
    logic            s_tready;
    logic [NS*8-1:0] m_tdata;
    logic [NS-1:0]   m_tvalid;
    logic [NS-1:0]   m_tlast;
    logic [NS-1:0]   m_tready;
    logic [15:0]     o_drop_count;
    logic            o_busy;

    tcp_port_dispatch #(.NUM_SOCK(NS), .IDX_W(IW)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx), .i_cfg_port(i_cfg_port), .i_cfg_en(i_cfg_en),
        .i_tcp_dest(i_tcp_dest), .i_tcp_dest_valid(i_tcp_dest_valid),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .o_drop_count(o_drop_count), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: the table as seen by the next lookup, and the expected drop count
    logic [15:0] mport [NS];
    logic        men   [NS];
    int          mcnt;

    typedef struct {
        logic        we;
        int          idx;
        logic [15:0] port;
        logic        en;
        logic [15:0] dest;
        int          nbeats;
        logic [7:0]  base;
        int          rdy;
        logic        gaps;
        int          mid_at;
        int          mw_idx;
        logic [15:0] mw_port;
        logic        mw_en;
        int          hold;
        int          exp_lane;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_lane(input logic [15:0] d);
        for (int i = 0; i < NS; i++) begin
            if (men[i] && mport[i] == d) return i;
        end
        return -1;
    endfunction

    function automatic vec_t mk(input logic we, input int idx, input logic [15:0] port, input logic en,
                                input logic [15:0] dest, input int nb, input logic [7:0] base,
                                input int rdy, input logic gaps, input int mid_at, input int mw_idx,
                                input logic [15:0] mw_port, input logic mw_en, input int hold,
                                input int exp_lane);
        vec_t v;
        v.we = we; v.idx = idx; v.port = port; v.en = en; v.dest = dest; v.nbeats = nb;
        v.base = base; v.rdy = rdy; v.gaps = gaps; v.mid_at = mid_at; v.mw_idx = mw_idx;
        v.mw_port = mw_port; v.mw_en = mw_en; v.hold = hold; v.exp_lane = exp_lane;
        return v;
    endfunction

    // all tasks are entered and left 1 time unit after a rising edge
    task automatic cfg_write(input int idx, input logic [15:0] port, input logic en);
        i_cfg_we = 1'b1; i_cfg_idx = IW'(idx); i_cfg_port = port; i_cfg_en = en;
        @(posedge clk); #1;
        i_cfg_we = 1'b0;
        mport[idx] = port; men[idx] = en;
    endtask

    task automatic run_pkt(input vec_t v);
        int   lane;
        int   beat = 0;
        int   cyc = 0;
        int   lastpos = -1;
        bit   done = 1'b0;
        bit   pend = 1'b0;
        logic [NS-1:0] mask;
        logic [7:0] got[$];
        if (v.we) cfg_write(v.idx, v.port, v.en);
        if (v.nbeats == 0) return;
        lane = (v.exp_lane == -99) ? model_lane(v.dest) : v.exp_lane;
        i_tcp_dest = v.dest;
        i_tcp_dest_valid = 1'b1;
        while (!done && cyc < 400) begin
            s_tvalid = (beat < v.nbeats) && (!v.gaps || $urandom_range(0, 3) != 0);
            s_tdata  = v.base + 8'(beat);
            s_tlast  = (beat == v.nbeats - 1);
            case (v.rdy)
                1:       m_tready = NS'($urandom);
                2:       m_tready = (cyc >= 4 && cyc < 7) ? '0 : '1;
                default: m_tready = '1;
            endcase
            @(negedge clk);
            mask = (cyc >= 2 && lane >= 0) ? NS'(1 << lane) : '0;
            chk("busy", o_busy, cyc != 0);
            chk("s_tready", s_tready, (cyc < 2) ? 1'b0 : (lane >= 0) ? m_tready[lane] : 1'b1);
            chk("other_tvalid", m_tvalid & ~mask, '0);
            chk("other_tlast", m_tlast & ~mask, '0);
            if (mask != '0) begin
                chk("lane_tvalid", m_tvalid[lane], s_tvalid);
                chk("lane_tlast", m_tlast[lane], s_tlast);
                chk("lane_tdata", m_tdata[lane*8 +: 8], s_tdata);
                if (m_tvalid[lane] && m_tready[lane]) begin
                    got.push_back(m_tdata[lane*8 +: 8]);
                    if (m_tlast[lane]) lastpos = got.size() - 1;
                end
            end
            if (s_tvalid && s_tready) begin
                if (beat == v.mid_at) pend = 1'b1;
                beat++;
                if (beat == v.nbeats) done = 1'b1;
            end
            @(posedge clk); #1;
            i_cfg_we = 1'b0;
            if ((pend && !done) || (v.mid_at == -1 && cyc == 0)) begin
                pend = 1'b0;
                i_cfg_we = 1'b1; i_cfg_idx = IW'(v.mw_idx); i_cfg_port = v.mw_port; i_cfg_en = v.mw_en;
                mport[v.mw_idx] = v.mw_port; men[v.mw_idx] = v.mw_en;
            end
            cyc++;
        end
        chk("pkt_complete", done, 1'b1);
        s_tvalid = 1'b0;
        i_cfg_we = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("done_busy", o_busy, 1'b1);
            chk("done_tready", s_tready, 1'b0);
            chk("done_tvalid", m_tvalid, '0);
            @(posedge clk); #1;
        end
        i_tcp_dest_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", o_busy, 1'b0);
        if (lane >= 0) begin
            chk("beats_rx", got.size(), v.nbeats);
            chk("tlast_pos", lastpos, v.nbeats - 1);
            for (int i = 0; i < got.size(); i++) chk("rx_byte", got[i], v.base + 8'(i));
        end else begin
            mcnt = (mcnt == 65535) ? 65535 : mcnt + 1;
        end
        chk("drop_count", o_drop_count, mcnt);
        @(posedge clk); #1;
    endtask

    vec_t vecs[12];

    initial begin
        logic [7:0] rgot[$];
        bit         rlast;
        int         beat;
        vec_t       v;

        vecs[0]  = mk(1, 1, 80,   1, 80,   5, 8'hA0, 0, 0, -2, 0, 0, 0, 4, 1);
        vecs[1]  = mk(1, 0, 443,  1, 0,    0, 8'h00, 0, 0, -2, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 2, 443,  1, 443,  4, 8'hB0, 1, 1, -2, 0, 0, 0, 1, 0);
        vecs[3]  = mk(0, 0, 0,    0, 1234, 3, 8'hC0, 0, 0, -2, 0, 0, 0, 1, -1);
        vecs[4]  = mk(1, 0, 443,  0, 443,  3, 8'h30, 1, 0, -2, 0, 0, 0, 0, 2);
        vecs[5]  = mk(1, 2, 8080, 1, 8080, 8, 8'hD0, 2, 0, -2, 0, 0, 0, 0, 2);
        vecs[6]  = mk(1, 3, 22,   1, 22,   6, 8'hE0, 0, 0, 2,  3, 22, 0, 0, 3);
        vecs[7]  = mk(0, 0, 0,    0, 22,   2, 8'h40, 0, 0, -2, 0, 0, 0, 0, -1);
        vecs[8]  = mk(0, 0, 0,    0, 80,   1, 8'h11, 0, 0, -2, 0, 0, 0, 2, 1);
        vecs[9]  = mk(0, 0, 0,    0, 80,   3, 8'h50, 0, 0, -1, 1, 80, 0, 0, 1);
        vecs[10] = mk(0, 0, 0,    0, 80,   2, 8'h60, 0, 0, -2, 0, 0, 0, 0, -1);
        vecs[11] = mk(1, 0, 80,   1, 80,   3, 8'h70, 1, 1, -2, 0, 0, 0, 1, 0);

        for (int i = 0; i < NS; i++) begin mport[i] = 16'd0; men[i] = 1'b0; end
        mcnt = 0;

        // reset with busy-looking inputs: outputs must stay quiet during and just after it
        i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_port = 16'd0; i_cfg_en = 1'b0;
        i_tcp_dest = 16'd80; i_tcp_dest_valid = 1'b1;
        s_tdata = 8'h5A; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = '1;
        @(negedge clk);
        chk("rst_tready", s_tready, 1'b0);
        chk("rst_tvalid", m_tvalid, '0);
        chk("rst_tlast", m_tlast, '0);
        chk("rst_busy", o_busy, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        i_rst = 1'b0; i_tcp_dest_valid = 1'b0; s_tvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", s_tready, 1'b0);
        chk("post_rst_tvalid", m_tvalid, '0);
        chk("post_rst_busy", o_busy, 1'b0);
        chk("post_rst_drops", o_drop_count, 16'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) run_pkt(vecs[i]);

        for (int r = 0; r < 30; r++) begin
            v = mk($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
                   16'(100 * $urandom_range(1, 5)), $urandom_range(0, 3) != 0,
                   16'(100 * $urandom_range(1, 6)), int'($urandom_range(1, 6)), 8'($urandom),
                   1, 1'b1, int'($urandom_range(0, 3)) - 2, int'($urandom_range(0, 3)),
                   16'(100 * $urandom_range(1, 5)), $urandom_range(0, 1) != 0,
                   int'($urandom_range(0, 3)), -99);
            run_pkt(v);
        end

        // reset in the middle of a forwarded packet
        cfg_write(0, 16'd9000, 1'b1);
        i_tcp_dest = 16'd9000; i_tcp_dest_valid = 1'b1; m_tready = '1;
        beat = 0; rlast = 1'b0;
        for (int c = 0; c < 20 && beat < 2; c++) begin
            s_tvalid = 1'b1; s_tdata = 8'hF0 + 8'(beat); s_tlast = (beat == 4);
            @(negedge clk);
            if (m_tvalid[0] && m_tready[0]) begin
                rgot.push_back(m_tdata[7:0]);
                rlast = rlast | m_tlast[0];
            end
            if (s_tvalid && s_tready) beat++;
            @(posedge clk); #1;
        end
        i_rst = 1'b1; i_tcp_dest_valid = 1'b0; s_tdata = 8'hF2;
        @(negedge clk);
        chk("midrst_tready", s_tready, 1'b0);
        chk("midrst_tvalid", m_tvalid, '0);
        chk("midrst_tlast", m_tlast, '0);
        chk("midrst_busy", o_busy, 1'b0);
        @(posedge clk); #1;
        i_rst = 1'b0; s_tvalid = 1'b0;
        for (int i = 0; i < NS; i++) begin mport[i] = 16'd0; men[i] = 1'b0; end
        mcnt = 0;
        @(negedge clk);
        chk("midrst_after_busy", o_busy, 1'b0);
        chk("midrst_after_drops", o_drop_count, 16'd0);
        chk("midrst_partial_beats", rgot.size(), 2);
        chk("midrst_no_tlast", rlast, 1'b0);
        @(posedge clk); #1;
        run_pkt(mk(0, 0, 0, 0, 16'd9000, 3, 8'hF2, 0, 0, -2, 0, 0, 0, 0, -1));

        // drop counter saturation near the top of its range
        force dut.drop_cnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.drop_cnt_q;
        mcnt = 65534;
        @(negedge clk);
        chk("preload_drops", o_drop_count, 16'hFFFE);
        @(posedge clk); #1;
        run_pkt(mk(0, 0, 0, 0, 16'd1, 3, 8'h21, 0, 0, -2, 0, 0, 0, 0, -1));
        run_pkt(mk(0, 0, 0, 0, 16'd1, 3, 8'h31, 0, 0, -2, 0, 0, 0, 0, -1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
